dmem_sized_wait: RTL and testbench

- Parametrised data memory for the MIPS pipeline MEM stage.
- Supports byte, halfword and word loads and stores, with sign or zero extension on loads.
- Requests go through a valid/ready handshake; a wait-state counter sets a configurable access latency.
- The MEM stage stalls on req_ready and rsp_valid. Misaligned and out-of-range accesses are flagged and never corrupt memory.

---
 rtl/dmem_pkg.sv | 33 +++
 rtl/dmem_lane_align.sv | 58 +++++
 rtl/dmem_sized_wait.sv | 150 +++++++++++++++
 tb/tb_dmem_sized_wait.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the sized data memory: size codes, FSM states
// and the byte-enable helper used by the lane aligner.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP,
        CLEAR
    } state_t;

    // Lane mask for a store; illegal size enables nothing.
    function automatic logic [3:0] byte_en(
        input logic [1:0] size,
        input logic [1:0] lane
    );
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: store replication, byte enables, load
// select/extend and alignment check.
// Ports: size, is_unsigned, lane (addr[1:0]), wdata, rword (array word)
//        in; wrep, be, rdata, misalign out.
import dmem_pkg::*;

module dmem_lane_align (
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] wrep,
    output logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        misalign
);

    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    logic [31:0] shifted;

    assign shifted = rword >> {lane, 3'b000};
    assign sel_b   = shifted[7:0];
    assign sel_h   = lane[1] ? rword[31:16] : rword[15:0];
    assign be      = byte_en(size, lane);

    // Illegal size is folded in here so the top sees a single check.
    assign misalign = ((size == SZ_HALF) && lane[0])
                    || ((size == SZ_WORD) && (lane != 2'b00))
                    || (size == 2'b11);

    always_comb begin
        wrep  = wdata;
        rdata = 32'd0;
        case (size)
            SZ_BYTE: begin
                wrep  = {4{wdata[7:0]}};
                rdata = is_unsigned ? {24'd0, sel_b}
                                    : {{24{sel_b[7]}}, sel_b};
            end
            SZ_HALF: begin
                wrep  = {2{wdata[15:0]}};
                rdata = is_unsigned ? {16'd0, sel_h}
                                    : {{16{sel_h[15]}}, sel_h};
            end
            SZ_WORD: begin
                wrep  = wdata;
                rdata = rword;
            end
            default: begin
                wrep  = wdata;
                rdata = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_sized_wait.sv
// MEM-stage data memory with byte/half/word access and wait states.
// Ports: clk, reset (async, active-low), req_* valid/ready request,
//        rsp_valid pulse with rsp_rdata/rsp_err. Macro DMEM_CLEAR_EN
//        adds a post-reset sweep that zeroes every word.
import dmem_pkg::*;

module dmem_sized_wait #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [3:0] WC_INIT =
        (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

`ifdef DMEM_CLEAR_EN
    localparam state_t RST_STATE = CLEAR;
    logic [AW-1:0] clr_idx;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        q_we, q_uns;
    logic [1:0]  q_size;
    logic [31:0] q_addr, q_wdata;

    logic [31:0] mem [DEPTH];

    logic [AW-1:0] idx;
    logic [31:0]   rword, wrep, rdata_ext;
    logic [3:0]    be;
    logic          misalign, range_err, err, do_write;

    assign idx       = q_addr[AW+1:2];
    assign rword     = mem[idx];
    assign range_err = (q_addr >> (AW + 2)) != 32'd0;
    assign err       = misalign || range_err;
    assign do_write  = (state == ACCESS) && q_we && !err;

    dmem_lane_align u_align (
        .size        (q_size),
        .is_unsigned (q_uns),
        .lane        (q_addr[1:0]),
        .wdata       (q_wdata),
        .rword       (rword),
        .wrep        (wrep),
        .be          (be),
        .rdata       (rdata_ext),
        .misalign    (misalign)
    );

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_n = ACCESS;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = WC_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_n = ACCESS;
                else             cnt_n   = cnt - 4'd1;
            end
            ACCESS: state_n = RESP;
            RESP:   state_n = IDLE;
            CLEAR: begin
`ifdef DMEM_CLEAR_EN
                if (clr_idx == AW'(DEPTH - 1)) state_n = IDLE;
`else
                state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RST_STATE;
            cnt       <= 4'd0;
            q_we      <= 1'b0;
            q_uns     <= 1'b0;
            q_size    <= SZ_WORD;
            q_addr    <= 32'd0;
            q_wdata   <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if ((state == IDLE) && req_valid) begin
                q_we    <= req_we;
                q_uns   <= req_unsigned;
                q_size  <= req_size;
                q_addr  <= req_addr;
                q_wdata <= req_wdata;
            end
            if (state == ACCESS) begin
                rsp_err   <= err;
                rsp_rdata <= (err || q_we) ? 32'd0 : rdata_ext;
            end
        end
    end

`ifdef DMEM_CLEAR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)               clr_idx <= '0;
        else if (state == CLEAR)  clr_idx <= clr_idx + 1'b1;
    end
`endif

    // Array has no reset; only enabled lanes are touched.
    always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_EN
        if (state == CLEAR) begin
            mem[clr_idx] <= 32'd0;
        end else
`endif
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_sized_wait.sv
// Self-checking bench: one instance with one wait state driven from a
// vector table, one zero-wait instance for back-to-back requests.
module tb_dmem_sized_wait;

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        a_valid = 0, a_ready, a_we = 0, a_uns = 0;
    logic [1:0]  a_size = 0;
    logic [31:0] a_addr = 0, a_wdata = 0, a_rsp_rdata;
    logic        a_rsp_valid, a_rsp_err;

    logic        b_valid = 0, b_ready, b_we = 0, b_uns = 0;
    logic [1:0]  b_size = 0;
    logic [31:0] b_addr = 0, b_wdata = 0, b_rsp_rdata;
    logic        b_rsp_valid, b_rsp_err;

    int checks = 0;
    int errors = 0;

    dmem_sized_wait #(.DEPTH(256), .WAIT_CYCLES(1)) u_a (
        .clk(clk), .reset(reset),
        .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
        .req_size(a_size), .req_unsigned(a_uns), .req_addr(a_addr),
        .req_wdata(a_wdata), .rsp_valid(a_rsp_valid),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    dmem_sized_wait #(.DEPTH(256), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .reset(reset),
        .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
        .req_size(b_size), .req_unsigned(b_uns), .req_addr(b_addr),
        .req_wdata(b_wdata), .rsp_valid(b_rsp_valid),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] sz,
                                input logic uns, input logic [31:0] a,
                                input logic [31:0] wd,
                                input logic [31:0] rd,
                                input logic er);
        vec_t t;
        t.we = we; t.sz = sz; t.uns = uns; t.addr = a;
        t.wdata = wd; t.rdata = rd; t.err = er;
        return t;
    endfunction

    task automatic req_a(input vec_t t, output logic [31:0] rd,
                         output logic er, output int lat);
        int n;
        n = 0;
        while (!a_ready && n < 5000) begin
            @(posedge clk); #1; n++;
        end
        a_we = t.we; a_size = t.sz; a_uns = t.uns;
        a_addr = t.addr; a_wdata = t.wdata; a_valid = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            a_valid = 1'b0;
        end while (!a_rsp_valid && lat < 20);
        rd = a_rsp_rdata;
        er = a_rsp_err;
        chk("rsp_valid seen", {31'd0, a_rsp_valid}, 32'd1);
        @(posedge clk); #1;
        chk("rsp_valid one cycle", {31'd0, a_rsp_valid}, 32'd0);
    endtask

    task automatic drive_b(input vec_t t);
        b_we = t.we; b_size = t.sz; b_uns = t.uns;
        b_addr = t.addr; b_wdata = t.wdata;
    endtask

    vec_t v[25];
    vec_t bq[4];
    logic [31:0] bexp[4];

    initial begin
        logic [31:0] rd;
        logic er, acc, seen;
        int lat, n, nacc, nrsp, cyc;
        int acc_cyc[4];
        vec_t t;

        v[0]  = mk(1, 2'b10, 0, 32'h20, 32'hDEADBEEF, 32'h0, 0);
        v[1]  = mk(0, 2'b10, 0, 32'h20, 32'h0, 32'hDEADBEEF, 0);
        v[2]  = mk(0, 2'b00, 0, 32'h21, 32'h0, 32'hFFFFFFBE, 0);
        v[3]  = mk(0, 2'b00, 1, 32'h21, 32'h0, 32'h000000BE, 0);
        v[4]  = mk(0, 2'b01, 0, 32'h22, 32'h0, 32'hFFFFDEAD, 0);
        v[5]  = mk(1, 2'b00, 0, 32'h23, 32'h00000055, 32'h0, 0);
        v[6]  = mk(0, 2'b10, 0, 32'h20, 32'h0, 32'h55ADBEEF, 0);
        v[7]  = mk(1, 2'b10, 0, 32'h22, 32'h11223344, 32'h0, 1);
        v[8]  = mk(1, 2'b01, 0, 32'h401, 32'h0000FFFF, 32'h0, 1);
        v[9]  = mk(0, 2'b10, 0, 32'h20, 32'h0, 32'h55ADBEEF, 0);
        v[10] = mk(1, 2'b00, 0, 32'h3FF, 32'h000000A5, 32'h0, 0);
        v[11] = mk(0, 2'b00, 1, 32'h3FF, 32'h0, 32'h000000A5, 0);
        v[12] = mk(0, 2'b00, 0, 32'h3FF, 32'h0, 32'hFFFFFFA5, 0);
        v[13] = mk(0, 2'b00, 0, 32'h400, 32'h0, 32'h0, 1);
        v[14] = mk(0, 2'b11, 0, 32'h20, 32'h0, 32'h0, 1);
        v[15] = mk(1, 2'b10, 0, 32'h24, 32'h00000000, 32'h0, 0);
        v[16] = mk(1, 2'b01, 0, 32'h26, 32'h12348001, 32'h0, 0);
        v[17] = mk(0, 2'b01, 0, 32'h26, 32'h0, 32'hFFFF8001, 0);
        v[18] = mk(0, 2'b01, 1, 32'h26, 32'h0, 32'h00008001, 0);
        v[19] = mk(0, 2'b10, 0, 32'h24, 32'h0, 32'h80010000, 0);
        v[20] = mk(0, 2'b01, 0, 32'h21, 32'h0, 32'h0, 1);
        v[21] = mk(0, 2'b10, 0, 32'h10000020, 32'h0, 32'h0, 1);
        v[22] = mk(1, 2'b10, 0, 32'h40, 32'hCAFEF00D, 32'h0, 0);
        v[23] = mk(0, 2'b01, 1, 32'h20, 32'h0, 32'h0000BEEF, 0);
        v[24] = mk(0, 2'b00, 0, 32'h20, 32'h0, 32'hFFFFFFEF, 0);

        bq[0] = mk(1, 2'b10, 0, 32'h10, 32'h11111111, 32'h0, 0);
        bq[1] = mk(1, 2'b10, 0, 32'h14, 32'h22222222, 32'h0, 0);
        bq[2] = mk(0, 2'b10, 0, 32'h10, 32'h0, 32'h0, 0);
        bq[3] = mk(0, 2'b10, 0, 32'h14, 32'h0, 32'h0, 0);
        bexp[0] = 32'h0;
        bexp[1] = 32'h0;
        bexp[2] = 32'h11111111;
        bexp[3] = 32'h22222222;

        #23;
`ifdef DMEM_CLEAR_EN
        chk("reset req_ready", {31'd0, a_ready}, 32'd0);
`else
        chk("reset req_ready", {31'd0, a_ready}, 32'd1);
`endif
        chk("reset rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
        chk("reset rsp_rdata", a_rsp_rdata, 32'd0);
        chk("reset rsp_err", {31'd0, a_rsp_err}, 32'd0);
        chk("reset b rsp_valid", {31'd0, b_rsp_valid}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < 25; i++) begin
            req_a(v[i], rd, er, lat);
            chk($sformatf("v%0d rdata", i), rd, v[i].rdata);
            chk($sformatf("v%0d err", i), {31'd0, er}, {31'd0, v[i].err});
            chk($sformatf("v%0d latency", i), lat, 32'd3);
        end

        n = 0;
        while (!b_ready && n < 5000) begin
            @(posedge clk); #1; n++;
        end
        nacc = 0; nrsp = 0; cyc = 0;
        for (int i = 0; i < 4; i++) acc_cyc[i] = 0;
        drive_b(bq[0]);
        b_valid = 1'b1;
        while (nrsp < 4 && cyc < 60) begin
            @(negedge clk);
            acc = b_valid && b_ready;
            if (b_rsp_valid) begin
                chk($sformatf("b2b rdata %0d", nrsp), b_rsp_rdata,
                    bexp[nrsp]);
                chk($sformatf("b2b err %0d", nrsp),
                    {31'd0, b_rsp_err}, 32'd0);
                chk($sformatf("b2b latency %0d", nrsp),
                    cyc - acc_cyc[nrsp], 32'd1);
                nrsp++;
            end
            @(posedge clk);
            cyc++;
            if (acc) begin
                acc_cyc[nacc] = cyc;
                nacc++;
                #1;
                if (nacc < 4) drive_b(bq[nacc]);
                else          b_valid = 1'b0;
            end
        end
        chk("b2b responses", nrsp, 32'd4);
        for (int i = 1; i < 4; i++)
            chk($sformatf("b2b accept gap %0d", i),
                acc_cyc[i] - acc_cyc[i-1], 32'd3);

        @(posedge clk); #1;
        t = mk(1, 2'b10, 0, 32'h40, 32'h12345678, 32'h0, 0);
        a_we = t.we; a_size = t.sz; a_uns = t.uns;
        a_addr = t.addr; a_wdata = t.wdata; a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        chk("ready low in WAIT", {31'd0, a_ready}, 32'd0);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen = seen | a_rsp_valid;
        end
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen = seen | a_rsp_valid;
        end
        chk("no rsp after abort", {31'd0, seen}, 32'd0);
        @(posedge clk); #1;
`ifdef DMEM_CLEAR_EN
        t = mk(0, 2'b10, 0, 32'h40, 32'h0, 32'h00000000, 0);
`else
        t = mk(0, 2'b10, 0, 32'h40, 32'h0, 32'hCAFEF00D, 0);
`endif
        req_a(t, rd, er, lat);
        chk("abort load rdata", rd, t.rdata);
        chk("abort load err", {31'd0, er}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
